// File: rtl/sparse_match_pe.sv
// Sparse activation x weight matching PE: walks compressed IA/weight lists and accumulates per-filter dot products.
// Optional macro PE_RELU_EN clamps negative results to zero when they are loaded into o_out_feature.
module sparse_match_pe #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned IA_DEPTH = 16,
    parameter int unsigned W_DEPTH  = 16,
    parameter int unsigned NUM_K    = 4,
    parameter int unsigned ACC_W    = 24,
    localparam int unsigned KW      = (NUM_K > 1) ? $clog2(NUM_K) : 1,
    localparam int unsigned IA_LW   = $clog2(IA_DEPTH) + 1,
    localparam int unsigned W_LW    = $clog2(W_DEPTH) + 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [IA_DEPTH*DATA_W-1:0]  i_ia_data,
    input  logic [IA_DEPTH*IDX_W-1:0]   i_ia_c_idx,
    input  logic [IA_LW-1:0]            i_ia_len,
    input  logic [W_DEPTH*DATA_W-1:0]   i_w_data,
    input  logic [W_DEPTH*IDX_W-1:0]    i_w_c_idx,
    input  logic [W_DEPTH*KW-1:0]       i_w_k_idx,
    input  logic [W_LW-1:0]             i_w_len,
    output logic                        o_busy,
    output logic                        o_finish,
    output logic [NUM_K*ACC_W-1:0]      o_out_feature
);
    localparam int unsigned IA_AW = $clog2(IA_DEPTH);
    localparam int unsigned W_AW  = $clog2(W_DEPTH);
    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned SW    = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic signed [SW-1:0] ACC_MAX = SW'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [IA_DEPTH*DATA_W-1:0]   ia_data_q, ia_data_d;
    logic [IA_DEPTH*IDX_W-1:0]    ia_c_q, ia_c_d;
    logic [IA_LW-1:0]             ia_len_q, ia_len_d;
    logic [W_DEPTH*DATA_W-1:0]    w_data_q, w_data_d;
    logic [W_DEPTH*IDX_W-1:0]     w_c_q, w_c_d;
    logic [W_DEPTH*KW-1:0]        w_k_q, w_k_d;
    logic [W_LW-1:0]              w_len_q, w_len_d;
    logic [IA_LW-1:0]             i_q, i_d;
    logic [W_LW-1:0]              j_q, j_d;
    logic [NUM_K*ACC_W-1:0]       acc_q, acc_d;
    logic                         busy_q, busy_d;
    logic                         finish_q, finish_d;
    logic [NUM_K*ACC_W-1:0]       out_q, out_d;

    logic signed [DATA_W-1:0]     ia_v_c, w_v_c;
    logic [IDX_W-1:0]             ia_ci_c, w_ci_c;
    logic [KW-1:0]                wk_c, wk_nxt_c;
    logic [W_LW-1:0]              j_inc_c;
    logic                         k_ok_c, k_change_c;
    logic signed [PW-1:0]         prod_c;
    logic signed [ACC_W-1:0]      acc_cur_c, acc_sat_c;
    logic signed [SW-1:0]         sum_c;
    logic                         adv_i_c, adv_j_c, acc_en_c;

    // Current entries under the two pointers; out-of-range pointers are never consumed.
    assign ia_v_c    = ia_data_q[32'(i_q[IA_AW-1:0]) * DATA_W +: DATA_W];
    assign ia_ci_c   = ia_c_q[32'(i_q[IA_AW-1:0]) * IDX_W +: IDX_W];
    assign w_v_c     = w_data_q[32'(j_q[W_AW-1:0]) * DATA_W +: DATA_W];
    assign w_ci_c    = w_c_q[32'(j_q[W_AW-1:0]) * IDX_W +: IDX_W];
    assign wk_c      = w_k_q[32'(j_q[W_AW-1:0]) * KW +: KW];
    assign j_inc_c   = j_q + W_LW'(1);
    assign wk_nxt_c  = w_k_q[32'(j_inc_c[W_AW-1:0]) * KW +: KW];
    assign k_change_c = (j_inc_c < w_len_q) && (wk_nxt_c != wk_c);

    if (NUM_K == (1 << KW)) begin : g_k_full
        assign k_ok_c = 1'b1;
    end else begin : g_k_part
        assign k_ok_c = (32'(wk_c) < NUM_K);
    end

    // Saturating multiply-accumulate into the selected filter.
    assign prod_c    = PW'(ia_v_c) * PW'(w_v_c);
    assign acc_cur_c = acc_q[32'(wk_c) * ACC_W +: ACC_W];
    assign sum_c     = SW'(acc_cur_c) + SW'(prod_c);
    assign acc_sat_c = (sum_c > ACC_MAX) ? ACC_W'(ACC_MAX) :
                       (sum_c < ACC_MIN) ? ACC_W'(ACC_MIN) : ACC_W'(sum_c);

    always_comb begin
        state_d   = state_q;
        ia_data_d = ia_data_q;
        ia_c_d    = ia_c_q;
        ia_len_d  = ia_len_q;
        w_data_d  = w_data_q;
        w_c_d     = w_c_q;
        w_k_d     = w_k_q;
        w_len_d   = w_len_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        finish_d  = 1'b0;
        out_d     = out_q;
        adv_i_c   = 1'b0;
        adv_j_c   = 1'b0;
        acc_en_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    ia_data_d = i_ia_data;
                    ia_c_d    = i_ia_c_idx;
                    ia_len_d  = (i_ia_len > IA_LW'(IA_DEPTH)) ? IA_LW'(IA_DEPTH) : i_ia_len;
                    w_data_d  = i_w_data;
                    w_c_d     = i_w_c_idx;
                    w_k_d     = i_w_k_idx;
                    w_len_d   = (i_w_len > W_LW'(W_DEPTH)) ? W_LW'(W_DEPTH) : i_w_len;
                    i_d       = '0;
                    j_d       = '0;
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (j_q >= w_len_q) begin
                    state_d  = S_DONE;
                    finish_d = 1'b1;
                    for (int unsigned k = 0; k < NUM_K; k++) begin
`ifdef PE_RELU_EN
                        out_d[k*ACC_W +: ACC_W] = acc_q[k*ACC_W + ACC_W - 1] ? '0 : acc_q[k*ACC_W +: ACC_W];
`else
                        out_d[k*ACC_W +: ACC_W] = acc_q[k*ACC_W +: ACC_W];
`endif
                    end
                end else begin
                    if (i_q >= ia_len_q) begin
                        adv_j_c = 1'b1;
                    end else if (ia_ci_c == w_ci_c) begin
                        adv_i_c  = k_ok_c;
                        adv_j_c  = 1'b1;
                        acc_en_c = k_ok_c;
                    end else if (ia_ci_c < w_ci_c) begin
                        adv_i_c = 1'b1;
                    end else begin
                        adv_j_c = 1'b1;
                    end
                    if (adv_i_c) i_d = i_q + IA_LW'(1);
                    // Entering a new filter group restarts the IA walk.
                    if (adv_j_c) begin
                        j_d = j_inc_c;
                        if (k_change_c) i_d = '0;
                    end
                    if (acc_en_c) acc_d[32'(wk_c) * ACC_W +: ACC_W] = acc_sat_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ia_data_q <= '0;
            ia_c_q    <= '0;
            ia_len_q  <= '0;
            w_data_q  <= '0;
            w_c_q     <= '0;
            w_k_q     <= '0;
            w_len_q   <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            ia_data_q <= ia_data_d;
            ia_c_q    <= ia_c_d;
            ia_len_q  <= ia_len_d;
            w_data_q  <= w_data_d;
            w_c_q     <= w_c_d;
            w_k_q     <= w_k_d;
            w_len_q   <= w_len_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            out_q     <= out_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_finish      = finish_q;
    assign o_out_feature = out_q;
endmodule
